out_port_buffer: RTL and testbench

OUT_PORT_BUFFER -- requirements
Module: out_port_buffer

---
 rtl/out_port_pkg.sv | 12 +
 rtl/out_port_fifo_mem.sv | 25 ++
 rtl/out_port_buffer.sv | 99 +++++++++
 tb/tb_out_port_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared constants and width helper for the CPU out-port buffer.
package out_port_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH_DEF = 8;

    // Pointer width for a power-of-two depth; level is one bit wider.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/out_port_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, no reset.
module out_port_fifo_mem
    import out_port_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_buffer.sv
// CPU out-port FIFO buffer with valid/ready device side and sticky overflow.
// Optional OUT_PORT_MIRROR_EN adds output_data, a copy of the last accepted word.
module out_port_buffer
    import out_port_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      Reset,
    input  logic                      clear,
    input  logic                      OutPortin,
    input  logic [DATA_W-1:0]         BusMuxOut,
    output logic                      out_stall,
    output logic [DATA_W-1:0]         dev_data,
    output logic                      dev_valid,
    input  logic                      dev_ready,
    output logic [ptr_w(DEPTH):0]     level,
    output logic                      overflow
`ifdef OUT_PORT_MIRROR_EN
    ,
    output logic [DATA_W-1:0]         output_data
`endif
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          ovf_q;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          lost;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        full  = (count == FULL_LVL);
        empty = (count == '0);
        pop   = !empty && dev_ready;
        push  = OutPortin && (!full || pop);
        lost  = OutPortin && full && !pop;
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (lost)
                ovf_q <= 1'b1;
        end
    end

    out_port_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_mem (
        .clock (clock),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (BusMuxOut),
        .raddr (rd_ptr),
        .rdata (dev_data)
    );

    assign out_stall = full;
    assign dev_valid = !empty;
    assign level     = count;
    assign overflow  = ovf_q;

`ifdef OUT_PORT_MIRROR_EN
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset)
            output_data <= '0;
        else if (push && !clear)
            output_data <= BusMuxOut;
    end
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed self-checking bench for out_port_buffer (DEPTH=8).
module tb_out_port_buffer;
    import out_port_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                  clock     = 1'b0;
    logic                  Reset     = 1'b1;
    logic                  clear     = 1'b0;
    logic                  OutPortin = 1'b0;
    logic [DATA_W-1:0]     BusMuxOut = '0;
    logic                  dev_ready = 1'b0;
    logic                  out_stall;
    logic [DATA_W-1:0]     dev_data;
    logic                  dev_valid;
    logic [3:0]            level;
    logic                  overflow;
`ifdef OUT_PORT_MIRROR_EN
    logic [DATA_W-1:0]     output_data;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    out_port_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .Reset     (Reset),
        .clear     (clear),
        .OutPortin (OutPortin),
        .BusMuxOut (BusMuxOut),
        .out_stall (out_stall),
        .dev_data  (dev_data),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef OUT_PORT_MIRROR_EN
        ,
        .output_data (output_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        OutPortin = 1'b1;
        BusMuxOut = w;
        tick();
        OutPortin = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Pops n words one per cycle, checking each against base+i before its pop edge.
    task automatic drain_expect(input string tag, input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            check_eq({tag, "_valid"}, 32'(dev_valid), 32'd1);
            check_eq({tag, "_data"}, dev_data, base + i);
            dev_ready = 1'b1;
            tick();
            dev_ready = 1'b0;
        end
        check_eq({tag, "_empty"}, 32'(level), 32'd0);
    endtask

    initial begin
        logic [31:0]  q[$];
        logic [31:0]  pat;
        int unsigned  sent;
        int unsigned  got;
        int unsigned  sz;
        logic         m_pop;
        logic         m_push;

        // Reset state
        #2 Reset = 1'b0;
        #1;
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_valid", 32'(dev_valid), 32'd0);
        check_eq("rst_stall", 32'(out_stall), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        // Three pushes, device not ready; first word visible right after its push edge
        push_word(32'hA000_0001);
        check_eq("p1_valid", 32'(dev_valid), 32'd1);
        check_eq("p1_data", dev_data, 32'hA000_0001);
        push_word(32'hA000_0002);
        push_word(32'hA000_0003);
        check_eq("p3_level", 32'(level), 32'd3);
        check_eq("p3_data", dev_data, 32'hA000_0001);
        check_eq("p3_valid", 32'(dev_valid), 32'd1);
        tick();
        check_eq("hold_data", dev_data, 32'hA000_0001);
        drain_expect("p3_drain", 32'hA000_0001, 3);

        // Underflow: ready while empty
        dev_ready = 1'b1;
        tick();
        tick();
        dev_ready = 1'b0;
        check_eq("uflow_level", 32'(level), 32'd0);
        check_eq("uflow_valid", 32'(dev_valid), 32'd0);

        // Fill to full, ninth write dropped and flagged
        do_clear();
        for (int unsigned i = 0; i < DEPTH; i++)
            push_word(32'hB000_0000 + i);
        check_eq("full_stall", 32'(out_stall), 32'd1);
        check_eq("full_level", 32'(level), 32'd8);
        check_eq("full_ovf0", 32'(overflow), 32'd0);
        push_word(32'hDEAD_DEAD);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        check_eq("ovf_level", 32'(level), 32'd8);
        check_eq("ovf_stall", 32'(out_stall), 32'd1);
        drain_expect("ovf_drain", 32'hB000_0000, 8);
        check_eq("ovf_nolost", 32'(dev_valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int unsigned i = 0; i < DEPTH; i++)
            push_word(32'hC000_0000 + i);
        OutPortin = 1'b1;
        BusMuxOut = 32'hC000_0008;
        dev_ready = 1'b1;
        tick();
        OutPortin = 1'b0;
        dev_ready = 1'b0;
        check_eq("pp_level", 32'(level), 32'd8);
        check_eq("pp_ovf", 32'(overflow), 32'd0);
        check_eq("pp_stall", 32'(out_stall), 32'd1);
        drain_expect("pp_drain", 32'hC000_0001, 8);

        // 20 pushes against a fixed ready pattern, checked with a queue model
        do_clear();
        pat  = 32'hB53A_96C7;
        sent = 0;
        got  = 0;
        for (int unsigned cyc = 0; cyc < 200 && (sent < 20 || q.size() != 0); cyc++) begin
            OutPortin = (sent < 20);
            BusMuxOut = 32'hD000_0000 + sent;
            dev_ready = pat[cyc % 32];
            sz     = q.size();
            m_pop  = (sz != 0) && dev_ready;
            m_push = OutPortin && ((sz < DEPTH) || m_pop);
            if (m_pop) begin
                check_eq("wrap_data", dev_data, q.pop_front());
                got++;
            end
            if (m_push) begin
                q.push_back(BusMuxOut);
                sent++;
            end
            tick();
            check_eq("wrap_level", 32'(level), 32'(q.size()));
        end
        OutPortin = 1'b0;
        dev_ready = 1'b0;
        check_eq("wrap_count", got, 32'd20);

        // Clear beats a concurrent push
        do_clear();
        for (int unsigned i = 0; i < 5; i++)
            push_word(32'hF000_0000 + i);
        check_eq("clr_pre_level", 32'(level), 32'd5);
        OutPortin = 1'b1;
        BusMuxOut = 32'h1234_5678;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        OutPortin = 1'b0;
        check_eq("clr_level", 32'(level), 32'd0);
        check_eq("clr_valid", 32'(dev_valid), 32'd0);
        check_eq("clr_ovf", 32'(overflow), 32'd0);
        tick();
        check_eq("clr_discard", 32'(dev_valid), 32'd0);

        // Asynchronous reset mid-burst while full and overflowed
        for (int unsigned i = 0; i < DEPTH + 1; i++)
            push_word(32'h5000_0000 + i);
        check_eq("ar_pre_ovf", 32'(overflow), 32'd1);
        OutPortin = 1'b1;
        BusMuxOut = 32'h5000_00FF;
        #2 Reset = 1'b0;
        #1;
        check_eq("ar_level", 32'(level), 32'd0);
        check_eq("ar_valid", 32'(dev_valid), 32'd0);
        check_eq("ar_stall", 32'(out_stall), 32'd0);
        check_eq("ar_ovf", 32'(overflow), 32'd0);
        OutPortin = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        push_word(32'hE000_0000);
        check_eq("ar_first_data", dev_data, 32'hE000_0000);
        check_eq("ar_first_level", 32'(level), 32'd1);

`ifdef OUT_PORT_MIRROR_EN
        push_word(32'h0000_BEEF);
        check_eq("mir_push", output_data, 32'h0000_BEEF);
        do_clear();
        check_eq("mir_clear", output_data, 32'h0000_BEEF);
        #2 Reset = 1'b0;
        #1;
        check_eq("mir_reset", output_data, 32'h0000_0000);
        tick();
        Reset = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
